// File: rtl/alu_mul_pkg.sv
// Shared definitions for the RV32M Booth multiplier.
// Contents:
//   MUL_OP_*  op encodings (funct3[1:0])
//   state_e   control FSM states
//   booth_sel_e and booth_sel()  radix-4 recode of a 3-bit window
//   sign_class()  operand-extension class of an op; MUL folds onto MULHU
//                 because the low product word does not depend on signedness.
package alu_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_sel_e;

  function automatic booth_sel_e booth_sel(input logic [2:0] b);
    case (b)
      3'b001, 3'b010: return PM;
      3'b011:         return P2M;
      3'b100:         return N2M;
      3'b101, 3'b110: return NM;
      default:        return ZERO;
    endcase
  endfunction

  function automatic logic [1:0] sign_class(input logic [1:0] op);
    return (op == MUL_OP_MUL) ? MUL_OP_MULHU : op;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth step, purely combinational.
// Ports:
//   acc_i  [W+1:0]  signed upper accumulator
//   lo_i   [W:0]    remaining multiplier bits plus guard bit in lo_i[0]
//   m_i    [W-1:0]  extended multiplicand
//   acc_o, lo_o     {acc+sel*M, lo} arithmetic-shifted right by 2
module booth_r4_step
  import alu_mul_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [W+1:0] acc_i,
  input  logic [W:0]   lo_i,
  input  logic [W-1:0] m_i,
  output logic [W+1:0] acc_o,
  output logic [W:0]   lo_o
);

  logic signed [W+1:0] m_ext, addend, sum;

  always_comb begin
    m_ext  = $signed({{2{m_i[W-1]}}, m_i});
    addend = '0;
    case (booth_sel(lo_i[2:0]))
      PM:      addend = m_ext;
      P2M:     addend = m_ext <<< 1;
      NM:      addend = -m_ext;
      N2M:     addend = -(m_ext <<< 1);
      default: addend = '0;
    endcase
    sum   = $signed(acc_i) + addend;
    // W+2 bits hold +-2M without overflow, so the sign of sum is exact.
    acc_o = {sum[W+1], sum[W+1], sum[W+1:2]};
    lo_o  = {sum[1:0], lo_i[W:2]};
  end

endmodule

// File: rtl/alu_booth_muldiv_ctl.sv
// Iterative radix-4 Booth multiplier for RV32M (MUL/MULH/MULHSU/MULHU).
// Ports:
//   clk, a_rst (async, active low)
//   in_valid/in_ready, op, rs1, rs2  request handshake (in_ready only in IDLE)
//   kill                             flush any in-flight op
//   out_valid/out_ready, result      response handshake, result held in DONE
//   busy                             state != IDLE
// Optional: define MUL_OPCACHE_EN to keep the last computed product and
// answer repeated operands (e.g. MULH then MUL) in one cycle.
module alu_booth_muldiv_ctl
  import alu_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int W    = XLEN + 2,
  parameter int ITER = W / 2,
  parameter int C    = $clog2(ITER + 1)
) (
  input  logic            clk,
  input  logic            a_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // Product register: {acc[W+1:0], multiplier[W-1:0], guard}.
  // After ITER steps the full product sits in prod_q[PW-1:1].
  localparam int PW = 2 * W + 3;

  state_e          state_q;
  logic [C-1:0]    cnt_q;
  logic [PW-1:0]   prod_q;
  logic [1:0]      op_q;
  logic [W-1:0]    m_q;
  logic            in_ready_q, out_valid_q, busy_q;

  logic [W-1:0]    ext1, ext2;
  logic [W+1:0]    step_acc;
  logic [W:0]      step_lo;
  logic [PW-1:0]   prod_nxt;
  logic [2*XLEN-1:0] full;

  always_comb begin
    ext1 = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ?
           {{(W-XLEN){rs1[XLEN-1]}}, rs1} : {{(W-XLEN){1'b0}}, rs1};
    ext2 = (op == MUL_OP_MULH) ?
           {{(W-XLEN){rs2[XLEN-1]}}, rs2} : {{(W-XLEN){1'b0}}, rs2};
  end

  booth_r4_step #(.W(W)) u_step (
    .acc_i (prod_q[PW-1:W+1]),
    .lo_i  (prod_q[W:0]),
    .m_i   (m_q),
    .acc_o (step_acc),
    .lo_o  (step_lo)
  );

  assign prod_nxt = {step_acc, step_lo};

`ifdef MUL_OPCACHE_EN
  logic [XLEN-1:0]   rs1_q, rs2_q, c_rs1_q, c_rs2_q;
  logic [1:0]        c_cls_q;
  logic [2*XLEN-1:0] c_prod_q;
  logic              c_vld_q, hit;

  // MUL only needs the low word, which is identical for every sign class.
  assign hit = c_vld_q && rs1 == c_rs1_q && rs2 == c_rs2_q &&
               (op == MUL_OP_MUL || sign_class(op) == c_cls_q);
`endif

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      op_q        <= MUL_OP_MUL;
      m_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MUL_OPCACHE_EN
      rs1_q       <= '0;
      rs2_q       <= '0;
      c_rs1_q     <= '0;
      c_rs2_q     <= '0;
      c_cls_q     <= '0;
      c_prod_q    <= '0;
      c_vld_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && !kill) begin
            op_q       <= op;
            m_q        <= ext1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef MUL_OPCACHE_EN
            rs1_q      <= rs1;
            rs2_q      <= rs2;
`endif
            if (rs1 == '0 || rs2 == '0) begin
              state_q     <= ST_DONE;
              prod_q      <= '0;
              out_valid_q <= 1'b1;
            end
`ifdef MUL_OPCACHE_EN
            else if (hit) begin
              state_q     <= ST_DONE;
              prod_q      <= {{(PW-2*XLEN-1){c_prod_q[2*XLEN-1]}}, c_prod_q, 1'b0};
              out_valid_q <= 1'b1;
            end
`endif
            else begin
              state_q <= ST_CALC;
              cnt_q   <= C'(ITER);
              prod_q  <= {{(W+2){1'b0}}, ext2, 1'b0};
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef MUL_OPCACHE_EN
            c_vld_q    <= 1'b0;
`endif
          end else begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q - C'(1);
            if (cnt_q == C'(1)) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
`ifdef MUL_OPCACHE_EN
              c_rs1_q     <= rs1_q;
              c_rs2_q     <= rs2_q;
              c_cls_q     <= sign_class(op_q);
              c_prod_q    <= prod_nxt[2*XLEN:1];
              c_vld_q     <= 1'b1;
`endif
            end
          end
        end
        ST_DONE: begin
          if (kill || out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign full      = prod_q[2*XLEN:1];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Gate to zero outside DONE so intermediate product bits never leak.
  assign result    = !out_valid_q ? '0 :
                     (op_q == MUL_OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

endmodule
